sort_mem_responder: RTL and testbench
=====================================

# sort_mem_responder

Memory-side responder for the sort circuit's five-channel read/write interface (AR/R, AW/W/B). It holds a word array, accepts one read and one write transaction at a time, returns read data and write responses, and flags out-of-range addresses. It is the bench and FPGA memory that the sort controller talks to, sitting on the far end of its memory ports.

## Interface
- ADDR_WDTH, 4, address width in words
- DATA_WDTH, 32, data word width
- RESP_WDTH, 1, response width; 0 = OKAY, 1 = ERROR (zero-extended when wider)
- MEM_DEPTH, 16, number of implemented words; must be ≤ 2^ADDR_WDTH

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- ar_address  in  ADDR_WDTH  read word address
- r_valid  out  1  read data valid
- r_ready  in  1  read data consumed
- r_data  out  DATA_WDTH  read data
- r_resp  out  RESP_WDTH  read response
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- aw_address  in  ADDR_WDTH  write word address
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- w_data  in  DATA_WDTH  write data
- b_valid  out  1  write response valid
- b_ready  in  1  write response consumed
- b_resp  out  RESP_WDTH  write response

## Operation
- A handshake occurs on any edge where valid and ready are both 1.
- Read FSM, states R_IDLE and R_RESP:
  - ar_ready = 1 only in R_IDLE.
  - AR handshake loads r_data from the pre-edge content of mem[ar_address] and moves to R_RESP.
  - ar_address ≥ MEM_DEPTH: r_data = 0, r_resp = 1. Otherwise r_resp = 0.
  - R_RESP holds r_valid = 1, with r_data and r_resp stable, until an r_ready handshake, then returns to R_IDLE.
- Write path:
  - Independent holding registers aw_held and w_held.
  - aw_ready = !aw_held && !b_valid; w_ready = !w_held && !b_valid.
  - AW and W are accepted in either order or in the same cycle.
  - Commit happens on the edge where the address is available (held or handshaking) and the data is available (held or handshaking). On that edge the block writes mem[addr] = w_data if addr < MEM_DEPTH, clears both holds, and sets b_valid = 1. b_resp = 1 if addr ≥ MEM_DEPTH; the array is then unchanged.
  - b_valid stays 1 until a b_ready handshake.
- Read and write paths are fully concurrent. If an AR handshake and a write commit to the same address fall on the same edge, the read returns the old data.
- Reset, mid-transaction: everything returns to reset values immediately. In-flight transactions are dropped and the array is cleared to 0.

## Timing
- Reset values:
  - ar_ready = 1, aw_ready = 1, w_ready = 1 (subject to stall gating, see Configuration)
  - r_valid = 0, b_valid = 0
  - r_data = 0, r_resp = 0, b_resp = 0
  - array all 0
- Read latency: r_valid rises the cycle after the AR handshake. Back-to-back reads sustain one read per 2 cycles (an r_ready handshake in cycle n allows AR acceptance in cycle n+1).
- Write latency: b_valid rises the cycle after the later of the AW and W handshakes.
- All outputs are registered or decoded from state only; there is no combinational path from any *_valid or *_ready input to any output.

## Configuration
- SORT_MEM_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'h01) advances every cycle.
  - ar_ready, aw_ready and w_ready are each additionally ANDed with lfsr[0]. Reset value of the LFSR output makes all three readies 1 after reset.
  - Used to stress the initiator's handshake logic.
- SORT_MEM_STALL_EN undefined: no LFSR; the readies are exactly as in Operation.

## Test plan
- Write then read: AW addr 3 and W 32'hDEADBEEF in the same cycle → b_valid next cycle with b_resp = 0. Then AR addr 3 → r_valid next cycle, r_data = 32'hDEADBEEF, r_resp = 0.
- Split write: W 32'h1234 two cycles before AW addr 5 → w_ready = 0 while held. Commit on the AW edge; a later read of addr 5 returns 32'h1234.
- Backpressure: hold r_ready = 0 for 4 cycles → r_valid and r_data stable, ar_ready = 0 throughout. Same check for b_valid with b_ready = 0; aw_ready and w_ready stay 0.
- Out of range, with MEM_DEPTH = 12:
  - write addr 14 → b_resp = 1, array unchanged
  - read addr 14 → r_data = 0, r_resp = 1
- Same-edge collision: addr 7 holds 32'hA. AR addr 7 on the same edge as a write commit of 32'hB to addr 7 → r_data = 32'hA; a following read returns 32'hB.
- Reset mid-transaction: assert rst while r_valid = 1 → r_valid = 0 and ar_ready = 1 immediately; a read of addr 3 after release returns 0.

Source files
------------

// File: rtl/sort_mem_responder.sv
// Word-addressed memory responder for the sort circuit's AR/R + AW/W/B ports.
// Optional ready stalling via an LFSR when SORT_MEM_STALL_EN is defined.
module sort_mem_responder #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MEM_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WDTH:0]   DEPTH_L   = MEM_DEPTH[ADDR_WDTH:0];
    localparam logic [RESP_WDTH-1:0] RESP_OKAY = '0;
    localparam logic [RESP_WDTH-1:0] RESP_ERR  = RESP_WDTH'(1);

    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    rd_state_t              r_rd_state;
    logic [DATA_WDTH-1:0]   r_mem [MEM_DEPTH];
    logic                   r_aw_held;
    logic                   r_w_held;
    logic [ADDR_WDTH-1:0]   r_aw_addr;
    logic [DATA_WDTH-1:0]   r_w_data;

    logic                   w_stall_ok;
    logic                   w_ar_hs;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [ADDR_WDTH-1:0]   w_wr_addr;
    logic [DATA_WDTH-1:0]   w_wr_data;
    logic                   w_wr_in_range;
    logic                   w_rd_in_range;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [IDX_W-1:0]       w_rd_idx;

`ifdef SORT_MEM_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; bit 0 gates all three readies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall_ok = r_lfsr[0];
`else
    assign w_stall_ok = 1'b1;
`endif

    // Readies decode from state only, so no input-to-output combinational path
    assign ar_ready = (r_rd_state == R_IDLE) && w_stall_ok;
    assign aw_ready = !r_aw_held && !b_valid && w_stall_ok;
    assign w_ready  = !r_w_held  && !b_valid && w_stall_ok;

    assign w_ar_hs       = ar_valid && ar_ready;
    assign w_aw_hs       = aw_valid && aw_ready;
    assign w_w_hs        = w_valid  && w_ready;
    assign w_commit      = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr     = r_aw_held ? r_aw_addr : aw_address;
    assign w_wr_data     = r_w_held  ? r_w_data  : w_data;
    assign w_wr_in_range = {1'b0, w_wr_addr}  < DEPTH_L;
    assign w_rd_in_range = {1'b0, ar_address} < DEPTH_L;
    assign w_wr_idx      = w_wr_addr[IDX_W-1:0];
    assign w_rd_idx      = ar_address[IDX_W-1:0];

    // Read FSM: sample the array before this edge's write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_state <= R_RESP;
                        r_valid    <= 1'b1;
                        if (w_rd_in_range) begin
                            r_data <= r_mem[w_rd_idx];
                            r_resp <= RESP_OKAY;
                        end else begin
                            r_data <= '0;
                            r_resp <= RESP_ERR;
                        end
                    end
                end
                R_RESP: begin
                    if (r_ready) begin
                        r_rd_state <= R_IDLE;
                        r_valid    <= 1'b0;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Write path: hold AW and W independently, commit once both are present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end
            if (w_commit) begin
                if (w_wr_in_range) begin
                    r_mem[w_wr_idx] <= w_wr_data;
                end
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                b_valid   <= 1'b1;
                b_resp    <= w_wr_in_range ? RESP_OKAY : RESP_ERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= aw_address;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= w_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_mem_responder.sv
// Bench for sort_mem_responder (MEM_DEPTH = 12): vector table plus scoreboard
// queues for R and B responses, with hand-written multi-cycle sequences.
module tb_sort_mem_responder;
    logic        clk;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  ar_address;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [0:0]  r_resp;
    logic        aw_valid;
    logic        aw_ready;
    logic [3:0]  aw_address;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        b_valid;
    logic        b_ready;
    logic [0:0]  b_resp;

    sort_mem_responder #(
        .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MEM_DEPTH(12)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_resp;
    } vec_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    vec_t vec[12];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: a valid&&ready seen at negedge handshakes on the next posedge
    always @(negedge clk) begin
        if (!rst && r_valid && r_ready) begin
            if (rd_q.size() == 0) begin
                timeout_fail("r_unexpected_response");
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                check("r_data", r_data, e.data);
                check("r_resp", {31'b0, r_resp}, {31'b0, e.resp});
            end
        end
        if (!rst && b_valid && b_ready) begin
            if (wr_q.size() == 0) begin
                timeout_fail("b_unexpected_response");
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                check("b_resp", {31'b0, b_resp}, {31'b0, e.resp});
            end
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        int   n = 0;
        logic aw_hs;
        logic w_hs;
        aw_address = a;
        w_data     = d;
        aw_valid   = 1'b1;
        w_valid    = 1'b1;
        while ((aw_valid || w_valid) && n < 50) begin
            aw_hs = aw_valid && aw_ready;
            w_hs  = w_valid && w_ready;
            step();
            n++;
            if (aw_hs) aw_valid = 1'b0;
            if (w_hs)  w_valid  = 1'b0;
        end
        if (aw_valid || w_valid) begin
            timeout_fail("write_accept");
            aw_valid = 1'b0;
            w_valid  = 1'b0;
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        int   n = 0;
        logic hs;
        ar_address = a;
        ar_valid   = 1'b1;
        while (ar_valid && n < 50) begin
            hs = ar_ready;
            step();
            n++;
            if (hs) ar_valid = 1'b0;
        end
        if (ar_valid) begin
            timeout_fail("read_accept");
            ar_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            timeout_fail("response_drain");
            rd_q.delete();
            wr_q.delete();
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        ar_valid = 1'b0; ar_address = '0; r_ready = 1'b1;
        aw_valid = 1'b0; aw_address = '0; w_valid = 1'b0; w_data = '0;
        b_ready = 1'b1;

        vec[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b1, 4'd14, 32'h00000055, 32'h0,        1'b1};
        vec[3]  = '{1'b0, 4'd14, 32'h0,        32'h0,        1'b1};
        vec[4]  = '{1'b1, 4'd0,  32'h11110000, 32'h0,        1'b0};
        vec[5]  = '{1'b1, 4'd11, 32'hCAFEF00D, 32'h0,        1'b0};
        vec[6]  = '{1'b0, 4'd11, 32'h0,        32'hCAFEF00D, 1'b0};
        vec[7]  = '{1'b0, 4'd0,  32'h0,        32'h11110000, 1'b0};
        vec[8]  = '{1'b1, 4'd12, 32'h00000077, 32'h0,        1'b1};
        vec[9]  = '{1'b0, 4'd12, 32'h0,        32'h0,        1'b1};
        vec[10] = '{1'b0, 4'd15, 32'h0,        32'h0,        1'b1};
        vec[11] = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0};

        step();
        step();
        check("reset_ar_ready", {31'b0, ar_ready}, 32'd1);
        check("reset_aw_ready", {31'b0, aw_ready}, 32'd1);
        check("reset_w_ready",  {31'b0, w_ready},  32'd1);
        check("reset_r_valid",  {31'b0, r_valid},  32'd0);
        check("reset_b_valid",  {31'b0, b_valid},  32'd0);
        check("reset_r_data",   r_data,            32'd0);
        check("reset_r_resp",   {31'b0, r_resp},   32'd0);
        check("reset_b_resp",   {31'b0, b_resp},   32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            if (vec[i].wr) begin
                wr_q.push_back('{data: 32'h0, resp: vec[i].exp_resp});
                do_write(vec[i].addr, vec[i].data);
            end else begin
                rd_q.push_back('{data: vec[i].exp_data, resp: vec[i].exp_resp});
                do_read(vec[i].addr);
            end
            wait_idle();
        end

        // Split write: W two cycles ahead of AW
        wr_q.push_back('{data: 32'h0, resp: 1'b0});
        w_data = 32'h00001234; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        check("split_w_ready_held", {31'b0, w_ready}, 32'd0);
        check("split_aw_ready_open", {31'b0, aw_ready}, 32'd1);
        step();
        check("split_w_ready_held2", {31'b0, w_ready}, 32'd0);
        check("split_no_b_yet", {31'b0, b_valid}, 32'd0);
        aw_address = 4'd5; aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        check("split_b_latency", {31'b0, b_valid}, 32'd1);
        wait_idle();
        rd_q.push_back('{data: 32'h00001234, resp: 1'b0});
        do_read(4'd5);
        wait_idle();

        // Read backpressure
        r_ready = 1'b0;
        rd_q.push_back('{data: 32'h00001234, resp: 1'b0});
        do_read(4'd5);
        for (int i = 0; i < 4; i++) begin
            check("rbp_r_valid", {31'b0, r_valid}, 32'd1);
            check("rbp_r_data", r_data, 32'h00001234);
            check("rbp_ar_ready", {31'b0, ar_ready}, 32'd0);
            step();
        end
        r_ready = 1'b1;
        wait_idle();

        // Write-response backpressure
        b_ready = 1'b0;
        wr_q.push_back('{data: 32'h0, resp: 1'b0});
        do_write(4'd4, 32'h0000ABCD);
        for (int i = 0; i < 4; i++) begin
            check("bbp_b_valid", {31'b0, b_valid}, 32'd1);
            check("bbp_aw_ready", {31'b0, aw_ready}, 32'd0);
            check("bbp_w_ready", {31'b0, w_ready}, 32'd0);
            step();
        end
        b_ready = 1'b1;
        wait_idle();
        rd_q.push_back('{data: 32'h0000ABCD, resp: 1'b0});
        do_read(4'd4);
        wait_idle();

        // Same-edge read and write commit on address 7
        wr_q.push_back('{data: 32'h0, resp: 1'b0});
        do_write(4'd7, 32'h0000000A);
        wait_idle();
        wr_q.push_back('{data: 32'h0, resp: 1'b0});
        rd_q.push_back('{data: 32'h0000000A, resp: 1'b0});
        w_data = 32'h0000000B; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        aw_address = 4'd7; aw_valid = 1'b1;
        ar_address = 4'd7; ar_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        check("coll_r_valid", {31'b0, r_valid}, 32'd1);
        check("coll_b_valid", {31'b0, b_valid}, 32'd1);
        wait_idle();
        rd_q.push_back('{data: 32'h0000000B, resp: 1'b0});
        do_read(4'd7);
        wait_idle();

        // Reset while a read response is pending
        r_ready = 1'b0;
        rd_q.push_back('{data: 32'hDEADBEEF, resp: 1'b0});
        do_read(4'd3);
        check("rstmid_r_valid_before", {31'b0, r_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_r_valid", {31'b0, r_valid}, 32'd0);
        check("rstmid_ar_ready", {31'b0, ar_ready}, 32'd1);
        rd_q.delete();
        r_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        rd_q.push_back('{data: 32'h0, resp: 1'b0});
        do_read(4'd3);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
